// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose rd feeds the ID instruction forces one bubble into EX.
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic [3:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc_plus2,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_alusrc,
  output logic [3:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc_plus2,
  output logic [CNT_W-1:0]  stall_count
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic              r_regwrite, r_memread, r_memwrite, r_memtoreg, r_alusrc;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm, r_pc_plus2;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_load_use;
  logic w_bubble;
  logic w_load;
  logic w_count;

  // Store data (rt of a store) is covered by MEM-to-MEM forwarding, so it never stalls.
  assign w_load_use = r_valid & r_memread & (r_rd != '0) & id_valid &
                      ((r_rd == id_rs) | (id_uses_rt & (r_rd == id_rt) & ~id_memwrite));

  assign hazard_stall = w_load_use & ~flush & ~rst;

  always_comb begin
    w_bubble = 1'b0;
    w_load   = 1'b0;
    w_count  = 1'b0;
    if (flush) begin
      w_bubble = 1'b1;
    end else if (!ex_stall) begin
      if (w_load_use) begin
        w_bubble = 1'b1;
        w_count  = 1'b1;
      end else if (!id_valid) begin
        w_bubble = 1'b1;
      end else begin
        w_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_alu_op   <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_pc_plus2 <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_alu_op   <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_pc_plus2 <= '0;
    end else if (w_load) begin
      r_valid    <= id_valid;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_regwrite <= id_regwrite;
      r_memread  <= id_memread;
      r_memwrite <= id_memwrite;
      r_memtoreg <= id_memtoreg;
      r_alusrc   <= id_alusrc;
      r_alu_op   <= id_alu_op;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
      r_pc_plus2 <= id_pc_plus2;
    end
  end

  // Saturating count of injected load-use bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_count && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rd       = r_rd;
  assign ex_regwrite = r_regwrite;
  assign ex_memread  = r_memread;
  assign ex_memwrite = r_memwrite;
  assign ex_memtoreg = r_memtoreg;
  assign ex_alusrc   = r_alusrc;
  assign ex_alu_op   = r_alu_op;
  assign ex_rs_data  = r_rs_data;
  assign ex_rt_data  = r_rt_data;
  assign ex_imm      = r_imm;
  assign ex_pc_plus2 = r_pc_plus2;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with a 3-bit counter covers saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [3:0]  id_alu_op;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_plus2;
  logic        flush, ex_stall;

  logic        hazard_stall, ex_valid;
  logic [3:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [3:0]  ex_alu_op;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus2;
  logic [15:0] stall_count;

  logic        s_hazard_stall, s_ex_valid;
  logic [3:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic        s_ex_regwrite, s_ex_memread, s_ex_memwrite, s_ex_memtoreg, s_ex_alusrc;
  logic [3:0]  s_ex_alu_op;
  logic [15:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm, s_ex_pc_plus2;
  logic [2:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_alu_op(id_alu_op), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc_plus2(id_pc_plus2), .flush(flush), .ex_stall(ex_stall),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
    .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_pc_plus2(ex_pc_plus2), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc),
    .id_alu_op(id_alu_op), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_pc_plus2(id_pc_plus2), .flush(flush), .ex_stall(ex_stall),
    .hazard_stall(s_hazard_stall), .ex_valid(s_ex_valid), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
    .ex_rd(s_ex_rd), .ex_regwrite(s_ex_regwrite), .ex_memread(s_ex_memread),
    .ex_memwrite(s_ex_memwrite), .ex_memtoreg(s_ex_memtoreg), .ex_alusrc(s_ex_alusrc),
    .ex_alu_op(s_ex_alu_op), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data),
    .ex_imm(s_ex_imm), .ex_pc_plus2(s_ex_pc_plus2), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic [3:0] rd, input logic ut, input logic rw, input logic mr,
                       input logic mw, input logic mt, input logic as, input logic [3:0] op,
                       input logic [15:0] rsd, input logic [15:0] rtd, input logic [15:0] imm,
                       input logic [15:0] pc);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ut;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mt; id_alusrc = as;
    id_alu_op = op; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_pc_plus2 = pc;
  endtask

  task automatic id_lw(input logic [3:0] rd, input logic [3:0] rs);
    drive(1'b1, rs, 4'd0, rd, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0,
          16'h1000, 16'h0, 16'h0004, 16'h0010);
  endtask

  task automatic id_add(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd);
    drive(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2,
          16'hA5A5, 16'h5A5A, 16'h0, 16'h0012);
  endtask

  task automatic id_sw(input logic [3:0] rs, input logic [3:0] rt);
    drive(1'b1, rs, rt, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0,
          16'h2000, 16'hBEEF, 16'h0008, 16'h0014);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
          16'h0, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    rst = 1'b0;

    // Reset asserted mid-cycle while a load sits in EX
    id_lw(4'd3, 4'd1);
    tick();
    chk("pre_rst_memread", ex_memread, 1);
    id_add(4'd3, 4'd1, 4'd6);
    #2 rst = 1'b1;
    #1;
    chk("rst_memread", ex_memread, 0);
    chk("rst_valid", ex_valid, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_pc", ex_pc_plus2, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_count", stall_count, 0);
    tick();
    rst = 1'b0;

    // Load-use on rs
    id_lw(4'd3, 4'd1);
    tick();
    id_add(4'd3, 4'd1, 4'd6);
    #1 chk("lu_rs_hazard", hazard_stall, 1);
    tick();
    chk("lu_rs_bubble_valid", ex_valid, 0);
    chk("lu_rs_bubble_rd", ex_rd, 0);
    chk("lu_rs_count", stall_count, 1);
    chk("lu_rs_hazard_gone", hazard_stall, 0);
    tick();
    chk("lu_rs_add_valid", ex_valid, 1);
    chk("lu_rs_add_rs", ex_rs, 3);
    chk("lu_rs_add_rd", ex_rd, 6);
    chk("lu_rs_add_data", ex_rs_data, 16'hA5A5);

    // Store data matching load rd: no stall
    id_lw(4'd5, 4'd1);
    tick();
    id_sw(4'd2, 4'd5);
    #1 chk("sw_rt_hazard", hazard_stall, 0);
    tick();
    chk("sw_rt_loaded", ex_memwrite, 1);
    chk("sw_rt_data", ex_rt_data, 16'hBEEF);
    chk("sw_rt_count", stall_count, 1);

    // Store address matching load rd: stall
    id_lw(4'd5, 4'd1);
    tick();
    id_sw(4'd5, 4'd7);
    #1 chk("sw_rs_hazard", hazard_stall, 1);
    tick();
    chk("sw_rs_bubble", ex_valid, 0);
    chk("sw_rs_count", stall_count, 2);
    tick();
    chk("sw_rs_loaded", ex_memwrite, 1);

    // Load to r0 never stalls
    id_lw(4'd0, 4'd1);
    tick();
    id_add(4'd0, 4'd0, 4'd6);
    #1 chk("r0_hazard", hazard_stall, 0);

    // rt match ignored when rt is not read
    id_lw(4'd4, 4'd1);
    tick();
    drive(1'b1, 4'd2, 4'd4, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1,
          16'h0, 16'h0, 16'h0033, 16'h0018);
    #1 chk("no_rt_hazard", hazard_stall, 0);
    tick();
    chk("no_rt_valid", ex_valid, 1);
    chk("no_rt_imm", ex_imm, 16'h0033);
    chk("no_rt_count", stall_count, 2);

    // Flush beats hazard and ex_stall
    id_lw(4'd3, 4'd1);
    tick();
    id_add(4'd3, 4'd1, 4'd6);
    flush = 1'b1; ex_stall = 1'b1;
    #1 chk("flush_hazard", hazard_stall, 0);
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_memread", ex_memread, 0);
    chk("flush_count", stall_count, 2);
    flush = 1'b0; ex_stall = 1'b0;

    // Deferred bubble under ex_stall
    id_lw(4'd3, 4'd1);
    tick();
    id_add(4'd3, 4'd1, 4'd6);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("defer_hazard", hazard_stall, 1);
      tick();
      chk("defer_hold_memread", ex_memread, 1);
      chk("defer_hold_rd", ex_rd, 3);
      chk("defer_count", stall_count, 2);
    end
    ex_stall = 1'b0;
    #1 chk("defer_release_hazard", hazard_stall, 1);
    tick();
    chk("defer_bubble", ex_valid, 0);
    chk("defer_count_inc", stall_count, 3);
    tick();
    chk("defer_add_rd", ex_rd, 6);

    // Non-valid ID entry loads as an uncounted bubble
    drive(1'b0, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3,
          16'h1111, 16'h2222, 16'h3333, 16'h4444);
    tick();
    chk("inval_valid", ex_valid, 0);
    chk("inval_regwrite", ex_regwrite, 0);
    chk("inval_memread", ex_memread, 0);
    chk("inval_count", stall_count, 3);

    // Saturation: 3-bit counter instance stops at 7
    chk("sat_start", s_stall_count, 3);
    for (int i = 0; i < 6; i++) begin
      id_lw(4'd3, 4'd1);
      tick();
      id_add(4'd3, 4'd1, 4'd6);
      tick();
    end
    chk("sat_main_count", stall_count, 9);
    chk("sat_small_count", s_stall_count, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
